tapasco_axi_mem_responder: RTL
==============================

// Module: tapasco_axi_mem_responder
// PURPOSE
//  AXI4 subordinate on the tapasco_axi slave-side port (5-bit IDs, req_slv_t/resp_slv_t); answers bursts
//  from the interconnect against a single-port word memory with req/gnt handshake and 1-cycle read latency.
//  Serves one transaction at a time: FIXED/INCR/WRAP bursts, narrow transfers, address-range decode, ATOP rejection.
// PARAMETERS
//  BaseAddr  64'h0      first byte address served
//  MemBytes  64'h10000  bytes served; addr >= BaseAddr+MemBytes (or < BaseAddr) -> DECERR
// PORTS
//  clk_i        in   1    clock
//  rst_i        in   1    synchronous reset, active-high
//  axi_req_i    in   req_slv_t   AW/W/AR channels + b_ready/r_ready
//  axi_resp_o   out  resp_slv_t  ready signals, B and R channels
//  mem_req_o    out  1    memory request, held until mem_gnt_i
//  mem_gnt_i    in   1    memory accepts request this cycle
//  mem_we_o     out  1    1 = write, 0 = read
//  mem_addr_o   out  64   byte address, bits [2:0] forced 0
//  mem_wdata_o  out  64   write data (W data unmodified)
//  mem_be_o     out  8    byte enables (W strb); 8'hFF on reads
//  mem_rdata_i  in   64   read data, valid exactly 1 cycle after req&gnt with we=0
// BEHAVIOUR
//  Reset: state IDLE; all ready/valid outputs 0, mem_req_o 0, RR pointer prefers AR; B/R payload 0.
//  FSM: IDLE -> WR_DATA -> WR_RESP -> IDLE ; IDLE -> RD_REQ -> RD_WAIT -> RD_DATA -> (RD_REQ | IDLE).
//  IDLE: aw_ready/ar_ready high only in IDLE; accept one of aw_valid/ar_valid. Both valid same cycle ->
//   round-robin (pointer flips to other channel after each grant). Accepted AW/AR captured to regs.
//  WR_DATA: w_ready = 1 when no mem request pending; beat taken -> mem_req_o=1, we=1 until gnt, then
//   next beat. Address advances per beat. w.last on beat len ends state (last not checked vs len;
//   count from len is authoritative, early/late last ignored). -> WR_RESP after final gnt.
//  WR_RESP: b_valid=1, b.id=captured id, resp per error rules, user=0; hold until b_ready -> IDLE.
//  RD_REQ: mem_req_o=1 we=0 until gnt -> RD_WAIT (1 cycle) -> RD_DATA: latch mem_rdata_i into R reg,
//   r_valid=1, r.id, r.last on beat len; hold stable until r_ready. r_ready&last -> IDLE else RD_REQ.
//   Throughput: 1 beat / 3 cycles minimum; no beat reordering, no interleaving.
//  Address gen: beat bytes = 1<<size. FIXED: constant. INCR: addr += 1<<size (64-bit wrap, no 4KB check).
//   WRAP: container = (len+1)<<size aligned; next = base | ((addr+(1<<size)) & (container-1)).
//   Narrow: mem_addr = addr & ~7; lanes from strb (writes), full word returned (reads).
//  Errors (per-transaction, decided on first beat address, sticky for burst):
//   out of range -> DECERR (2'b11): writes drain W, no mem_req; reads return data 0, no mem_req.
//   aw.atop != 0 -> SLVERR (2'b10), W drained, no mem writes. Otherwise OKAY.
//   Read error beats skip RD_REQ/RD_WAIT (RD_DATA directly). Unsupported burst 2'b11 treated as INCR.
//  mem_req_o, once raised, holds addr/we/wdata/be stable until gnt. Reset mid-burst abandons it silently.
// STRUCTURE
//  Package tapasco_axi: add resp_state_e enum and BeatBytes = StrbWidth localparam; reuse id_slv_t/addr_t.
//  Sub-module tapasco_axi_burst_addr (combinational: addr, len, size, burst -> next addr).
// TESTING
//  Single write then read: AW addr 0x40 len0 size3 data 0xDEAD_BEEF strb FF -> B OKAY id echoed; AR 0x40 -> R 0xDEADBEEF last=1.
//  INCR len3 size3 at 0x100 -> mem_addr 0x100,0x108,0x110,0x118; r.last only on 4th beat.
//  WRAP len3 size3 at 0x118 -> addrs 0x118,0x100,0x108,0x110; FIXED len3 -> 0x118 four times.
//  AW and AR valid same cycle twice -> first AR granted, next arbitration grants AW; gnt stalled 5 cycles keeps mem_* stable.
//  AR at BaseAddr+MemBytes len1 -> two R beats data 0 resp DECERR, no mem_req_o; AW with atop=6'h20 -> B SLVERR, no we.
//  rst_i asserted mid write burst (beat 2 of 4) -> next cycle all valids/req 0, state IDLE, new AR served normally.

Source files
------------

// File: rtl/tapasco_axi_mem_responder_pkg.sv
// tapasco_axi: slave-side AXI4 channel bundles (5-bit IDs, 64-bit data)
// plus the responder state encoding.
package tapasco_axi;
    localparam int unsigned IdWidth   = 5;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned BeatBytes = StrbWidth;

    typedef logic [IdWidth-1:0]   id_slv_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [UserWidth-1:0] user_t;
    typedef logic [7:0]           len_t;
    typedef logic [2:0]           size_t;
    typedef logic [1:0]           burst_t;
    typedef logic [1:0]           resp_t;
    typedef logic [5:0]           atop_t;

    localparam burst_t BurstFixed = 2'b00;
    localparam burst_t BurstIncr  = 2'b01;
    localparam burst_t BurstWrap  = 2'b10;

    localparam resp_t RespOkay   = 2'b00;
    localparam resp_t RespSlvErr = 2'b10;
    localparam resp_t RespDecErr = 2'b11;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        len_t       len;
        size_t      size;
        burst_t     burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        atop_t      atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_slv_t id;
        resp_t   resp;
        user_t   user;
    } b_chan_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        len_t       len;
        size_t      size;
        burst_t     burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_slv_t id;
        data_t   data;
        resp_t   resp;
        logic    last;
        user_t   user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_slv_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DATA
    } resp_state_e;
endpackage

// File: rtl/tapasco_axi_mem_responder_burst_addr.sv
// tapasco_axi_burst_addr: next beat address for FIXED/INCR/WRAP bursts.
// Reserved burst encoding falls through to INCR.
module tapasco_axi_burst_addr
    import tapasco_axi::*;
(
    input  addr_t  i_addr,
    input  len_t   i_len,
    input  size_t  i_size,
    input  burst_t i_burst,
    output addr_t  o_next
);
    addr_t w_step;
    addr_t w_mask;
    addr_t w_incr;

    assign w_step = addr_t'(1) << i_size;
    assign w_mask = ((addr_t'(i_len) + addr_t'(1)) << i_size) - addr_t'(1);
    assign w_incr = i_addr + w_step;

    always_comb begin
        o_next = w_incr;
        unique case (i_burst)
            BurstFixed: o_next = i_addr;
            BurstWrap:  o_next = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:    o_next = w_incr;
        endcase
    end
endmodule

// File: rtl/tapasco_axi_mem_responder.sv
// tapasco_axi_mem_responder: single-outstanding AXI4 subordinate in front of
// a req/gnt word memory with one cycle of read latency.
module tapasco_axi_mem_responder
    import tapasco_axi::*;
#(
    parameter logic [63:0] BaseAddr = 64'h0,
    parameter logic [63:0] MemBytes = 64'h10000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  req_slv_t    axi_req_i,
    output resp_slv_t   axi_resp_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_be_o,
    input  logic [63:0] mem_rdata_i
);
    resp_state_e r_state;
    resp_state_e w_next_state;

    id_slv_t r_id;
    addr_t   r_addr;
    len_t    r_len;
    size_t   r_size;
    burst_t  r_burst;
    len_t    r_cnt;
    resp_t   r_err;
    logic    r_rr;
    logic    r_wpend;
    data_t   r_wdata;
    strb_t   r_be;
    data_t   r_rdata;

    addr_t w_next_addr;
    logic  w_idle;
    logic  w_gnt_aw;
    logic  w_gnt_ar;
    logic  w_w_ready;
    logic  w_w_hs;
    logic  w_r_hs;
    logic  w_last_beat;
    logic  w_wr_done;
    resp_t w_aw_err;
    resp_t w_ar_err;
    logic  w_unused;

    function automatic logic in_range(input addr_t a);
        return (a >= BaseAddr) && ((a - BaseAddr) < MemBytes);
    endfunction

    tapasco_axi_burst_addr u_burst_addr (
        .i_addr  (r_addr),
        .i_len   (r_len),
        .i_size  (r_size),
        .i_burst (r_burst),
        .o_next  (w_next_addr)
    );

    // r_rr = 1 means AR wins a simultaneous request
    assign w_idle    = (r_state == ST_IDLE) && !rst_i;
    assign w_gnt_ar  = w_idle && axi_req_i.ar_valid &&
                       (!axi_req_i.aw_valid || r_rr);
    assign w_gnt_aw  = w_idle && axi_req_i.aw_valid && !w_gnt_ar;
    assign w_w_ready = (r_state == ST_WR_DATA) && !r_wpend && !rst_i;
    assign w_w_hs    = w_w_ready && axi_req_i.w_valid;
    assign w_r_hs    = (r_state == ST_RD_DATA) && axi_req_i.r_ready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_wr_done = (r_err != RespOkay) ? w_w_hs : (r_wpend && mem_gnt_i);

    assign w_aw_err = !in_range(axi_req_i.aw.addr) ? RespDecErr :
                      (axi_req_i.aw.atop != '0)    ? RespSlvErr : RespOkay;
    assign w_ar_err = !in_range(axi_req_i.ar.addr) ? RespDecErr : RespOkay;

    assign w_unused = ^{axi_req_i, r_addr[2:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_aw) begin
                    w_next_state = ST_WR_DATA;
                end else if (w_gnt_ar) begin
                    w_next_state = (w_ar_err != RespOkay) ? ST_RD_DATA : ST_RD_REQ;
                end
            end
            ST_WR_DATA: begin
                if (w_wr_done && w_last_beat) w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (axi_req_i.b_ready) w_next_state = ST_IDLE;
            end
            ST_RD_REQ: begin
                if (mem_gnt_i) w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: w_next_state = ST_RD_DATA;
            ST_RD_DATA: begin
                if (axi_req_i.r_ready) begin
                    if (w_last_beat) w_next_state = ST_IDLE;
                    else if (r_err != RespOkay) w_next_state = ST_RD_DATA;
                    else w_next_state = ST_RD_REQ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= RespOkay;
            r_rr    <= 1'b1;
            r_wpend <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_gnt_aw) begin
                r_id    <= axi_req_i.aw.id;
                r_addr  <= axi_req_i.aw.addr;
                r_len   <= axi_req_i.aw.len;
                r_size  <= axi_req_i.aw.size;
                r_burst <= axi_req_i.aw.burst;
                r_cnt   <= '0;
                r_err   <= w_aw_err;
                r_rr    <= 1'b1;
            end else if (w_gnt_ar) begin
                r_id    <= axi_req_i.ar.id;
                r_addr  <= axi_req_i.ar.addr;
                r_len   <= axi_req_i.ar.len;
                r_size  <= axi_req_i.ar.size;
                r_burst <= axi_req_i.ar.burst;
                r_cnt   <= '0;
                r_err   <= w_ar_err;
                r_rr    <= 1'b0;
                r_rdata <= '0;
            end
            // errored writes drain W without ever raising a request
            if (w_w_hs && (r_err == RespOkay)) begin
                r_wpend <= 1'b1;
                r_wdata <= axi_req_i.w.data;
                r_be    <= axi_req_i.w.strb;
            end
            if ((r_state == ST_WR_DATA) && w_wr_done) begin
                r_wpend <= 1'b0;
                r_cnt   <= r_cnt + 8'd1;
                r_addr  <= w_next_addr;
            end
            if (r_state == ST_RD_WAIT) r_rdata <= mem_rdata_i;
            if (w_r_hs) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= w_next_addr;
            end
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = w_idle && (!axi_req_i.ar_valid || !r_rr);
        axi_resp_o.ar_ready = w_idle && (!axi_req_i.aw_valid || r_rr);
        axi_resp_o.w_ready  = w_w_ready;
        if (r_state == ST_WR_RESP) begin
            axi_resp_o.b_valid = 1'b1;
            axi_resp_o.b.id    = r_id;
            axi_resp_o.b.resp  = r_err;
        end
        if (r_state == ST_RD_DATA) begin
            axi_resp_o.r_valid = 1'b1;
            axi_resp_o.r.id    = r_id;
            axi_resp_o.r.data  = r_rdata;
            axi_resp_o.r.resp  = r_err;
            axi_resp_o.r.last  = w_last_beat;
        end
        mem_req_o   = (r_state == ST_RD_REQ) ||
                      ((r_state == ST_WR_DATA) && r_wpend);
        mem_we_o    = (r_state == ST_WR_DATA);
        mem_addr_o  = {r_addr[63:3], 3'b000};
        mem_wdata_o = r_wdata;
        mem_be_o    = mem_we_o ? r_be : 8'hFF;
    end
endmodule
